// File: rtl/cargador_operandos_if.sv
// Operand-loader bus: switch/button inputs, operand drive to the adder,
// adder answer return and the registered result/status outputs.
interface cargador_operandos_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] data_in;
  logic         load;
  logic         clear;
  logic [N-1:0] input1;
  logic [N-1:0] input2;
  logic [N-1:0] answer;
  logic [N-1:0] result;
  logic         result_valid;
  logic [1:0]   state;

  modport master (
    output data_in, load, clear, answer,
    input  input1, input2, result, result_valid, state
  );

  modport slave (
    input  data_in, load, clear, answer,
    output input1, input2, result, result_valid, state
  );
endinterface

// File: rtl/cargador_operandos.sv
// Sequential front-end for the ripple-carry adder: captures A then B from a
// shared switch bus on button presses and registers the adder's sum.
module cargador_operandos #(
  parameter int unsigned N = 4
) (
  input logic                 clk,
  input logic                 rst,
  cargador_operandos_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT_B = 2'b01,
    CALC   = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] input1_q, input1_d;
  logic [N-1:0] input2_q, input2_d;
  logic [N-1:0] result_q, result_d;
  logic         valid_q, valid_d;
  logic         s1_q, s1_d;
  logic         s2_q, s2_d;
  logic         s3_q, s3_d;
  logic         load_pulse;

  always_comb begin
    s1_d       = bus.load;
    s2_d       = s1_q;
    s3_d       = s2_q;
    load_pulse = s2_q & ~s3_q;

    state_d  = state_q;
    input1_d = input1_q;
    input2_d = input2_q;
    result_d = result_q;
    valid_d  = valid_q;

    // clear wins over any coincident load pulse, which is simply lost
    if (bus.clear) begin
      state_d  = IDLE;
      input1_d = '0;
      input2_d = '0;
      result_d = '0;
      valid_d  = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (load_pulse) begin
          input1_d = bus.data_in;
          state_d  = WAIT_B;
        end
        WAIT_B: if (load_pulse) begin
          input2_d = bus.data_in;
          state_d  = CALC;
        end
        CALC: begin
          result_d = bus.answer;
          valid_d  = 1'b1;
          state_d  = DONE;
        end
        DONE: if (load_pulse) begin
          input1_d = bus.data_in;
          valid_d  = 1'b0;
          state_d  = WAIT_B;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      input1_q <= '0;
      input2_q <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      input1_q <= input1_d;
      input2_q <= input2_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      s3_q     <= s3_d;
    end
  end

  assign bus.input1       = input1_q;
  assign bus.input2       = input2_q;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_cargador_operandos.sv
// Bench for cargador_operandos: an edge-level reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_cargador_operandos;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cargador_operandos_if #(.N(N)) bus ();
  assign bus.answer = bus.input1 + bus.input2;

  cargador_operandos #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: a press is seen when load was high two edges ago and low three
  // edges ago; operations follow the A/B/sum sequence described by flags.
  logic       h0, h1, h2;
  logic [3:0] m_a, m_b, m_r;
  logic       m_v, m_have_a, m_calc, m_done;
  logic       m_pulse;
  logic [1:0] m_state;
  assign m_pulse = h1 & ~h2;
  assign m_state = m_calc ? 2'd2 : m_have_a ? 2'd1 : m_done ? 2'd3 : 2'd0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      h0 <= 1'b0; h1 <= 1'b0; h2 <= 1'b0;
      m_a <= 4'd0; m_b <= 4'd0; m_r <= 4'd0; m_v <= 1'b0;
      m_have_a <= 1'b0; m_calc <= 1'b0; m_done <= 1'b0;
    end else begin
      h0 <= bus.load; h1 <= h0; h2 <= h1;
      if (bus.clear) begin
        m_a <= 4'd0; m_b <= 4'd0; m_r <= 4'd0; m_v <= 1'b0;
        m_have_a <= 1'b0; m_calc <= 1'b0; m_done <= 1'b0;
      end else if (m_calc) begin
        m_r <= 4'((int'(m_a) + int'(m_b)) % 16);
        m_v <= 1'b1;
        m_calc <= 1'b0;
        m_done <= 1'b1;
      end else if (m_pulse) begin
        if (!m_have_a) begin
          m_a <= bus.data_in;
          m_v <= 1'b0;
          m_have_a <= 1'b1;
          m_done <= 1'b0;
        end else begin
          m_b <= bus.data_in;
          m_have_a <= 1'b0;
          m_calc <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      check("model input1", int'(bus.input1), int'(m_a));
      check("model input2", int'(bus.input2), int'(m_b));
      check("model result", int'(bus.result), int'(m_r));
      check("model result_valid", int'(bus.result_valid), int'(m_v));
      check("model state", int'(bus.state), int'(m_state));
    end
  end

  task automatic press(input logic [3:0] v);
    @(negedge clk);
    bus.data_in = v;
    bus.load = 1'b1;
    repeat (4) @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " input1"}, int'(bus.input1), 0);
    check({tag, " input2"}, int'(bus.input2), 0);
    check({tag, " result"}, int'(bus.result), 0);
    check({tag, " result_valid"}, int'(bus.result_valid), 0);
    check({tag, " state"}, int'(bus.state), 0);
  endtask

  initial begin
    bus.data_in = 4'd0;
    bus.load    = 1'b0;
    bus.clear   = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    #2 rst = 1'b1;

    // T1 basic
    press(4'd3);
    press(4'd5);
    check("t1 input1", int'(bus.input1), 3);
    check("t1 input2", int'(bus.input2), 5);
    check("t1 result", int'(bus.result), 8);
    check("t1 result_valid", int'(bus.result_valid), 1);
    check("t1 state", int'(bus.state), 3);

    // T6 restart from DONE
    press(4'd10);
    check("t6 result_valid", int'(bus.result_valid), 0);
    check("t6 result held", int'(bus.result), 8);
    check("t6 state", int'(bus.state), 1);
    check("t6 input1", int'(bus.input1), 10);
    press(4'd2);
    check("t6 result", int'(bus.result), 12);
    check("t6 result_valid2", int'(bus.result_valid), 1);

    // T2 wrap
    press(4'd9);
    press(4'd9);
    check("t2 result 9+9", int'(bus.result), 2);
    check("t2 result_valid", int'(bus.result_valid), 1);
    press(4'd15);
    press(4'd1);
    check("t2 result 15+1", int'(bus.result), 0);

    // T3 held button
    do_clear();
    @(negedge clk);
    bus.data_in = 4'd7;
    bus.load = 1'b1;
    repeat (10) @(negedge clk);
    bus.data_in = 4'd2;
    repeat (10) @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    check("t3 input1", int'(bus.input1), 7);
    check("t3 state", int'(bus.state), 1);

    // T4 clear coincident with the load pulse
    do_clear();
    press(4'd4);
    check("t4 state before", int'(bus.state), 1);
    @(negedge clk);
    bus.data_in = 4'd9;
    bus.load = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.clear = 1'b1;
    @(negedge clk);
    bus.clear = 1'b0;
    check_zero("t4");
    repeat (3) @(negedge clk);
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
    check("t4 state after", int'(bus.state), 0);

    // T5 asynchronous reset while in CALC
    press(4'd2);
    @(negedge clk);
    bus.data_in = 4'd4;
    bus.load = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("t5 in calc", int'(bus.state), 2);
    rst = 1'b0;
    bus.load = 1'b0;
    #1;
    check_zero("t5 async");
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    press(4'd6);
    press(4'd1);
    check("t5 result", int'(bus.result), 7);
    check("t5 result_valid", int'(bus.result_valid), 1);
    check("t5 state", int'(bus.state), 3);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
